// File: rtl/weight_fifo_ctrl.sv
// rtl/weight_fifo_ctrl.sv - load/drain sequencer for the systolic-array weight shift FIFO
module weight_fifo_ctrl #(
    parameter int array_size = 4,
    parameter int fifo_depth = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  drain_go,
    input  logic                  stall,
    output logic [array_size-1:0] fifo_en,
    output logic [array_size-1:0] col_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int D  = fifo_depth + array_size - 1;
    localparam int RW = $clog2(fifo_depth + 1);
    localparam int CW = $clog2(D + 1);

    localparam logic [RW-1:0] ROW_LAST = RW'(fifo_depth - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(D - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FULL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [RW-1:0]           r_row_cnt;
    logic [CW-1:0]           r_cyc_cnt;
    logic [array_size-1:0]   r_col_valid;
    logic [array_size-1:0]   w_fifo_en;

    // Column i is enabled for the fifo_depth drain cycles starting at cycle i.
    always_comb begin
        w_fifo_en = '0;
        case (r_state)
            S_LOAD:  w_fifo_en = {array_size{load_valid}};
            S_DRAIN: begin
                for (int i = 0; i < array_size; i++) begin
                    w_fifo_en[i] = !stall
                                   && (int'(r_cyc_cnt) >= i)
                                   && (int'(r_cyc_cnt) < i + fifo_depth);
                end
            end
            default: w_fifo_en = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_row_cnt   <= '0;
            r_cyc_cnt   <= '0;
            r_col_valid <= '0;
        end else begin
            r_col_valid <= w_fifo_en;
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    if (load_valid) begin
                        r_row_cnt <= r_row_cnt + RW'(1);
                        if (r_row_cnt == ROW_LAST) r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (drain_go) begin
                        r_cyc_cnt <= '0;
                        r_state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        r_cyc_cnt <= r_cyc_cnt + CW'(1);
                        if (r_cyc_cnt == CYC_LAST) r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_row_cnt <= '0;
                    r_cyc_cnt <= '0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fifo_en    = w_fifo_en;
    assign col_valid  = r_col_valid;
    assign load_ready = (r_state == S_LOAD);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_weight_fifo_ctrl.sv
// tb/tb_weight_fifo_ctrl.sv - directed self-checking bench for weight_fifo_ctrl
module tb_weight_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       load_valid = 1'b0;
    logic       drain_go = 1'b0;
    logic       stall = 1'b0;
    logic       load_ready;
    logic [3:0] fifo_en;
    logic [3:0] col_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] drain_pat [11] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111,
                                   4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    weight_fifo_ctrl #(.array_size(4), .fifo_depth(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .drain_go   (drain_go),
        .stall      (stall),
        .fifo_en    (fifo_en),
        .col_valid  (col_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
    task automatic step(input logic st, input logic lv, input logic dg, input logic sl);
        @(negedge clk);
        start = st; load_valid = lv; drain_go = dg; stall = sl;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(0, 0, 0, 0);
        n_checks++;
        if ({load_ready, fifo_en, col_valid, busy, done} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", {load_ready, fifo_en, col_valid, busy, done});
        end
        @(negedge clk);
        reset = 1'b1;
        step(0, 1, 1, 1);
        n_checks++;
        if (busy !== 1'b0 || fifo_en !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_inputs: busy=%b fifo_en=%b required 0/0000", busy, fifo_en);
        end
    endtask

    task automatic test_load_full(input bit noisy);
        step(1, 0, 0, 0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_idle_busy: got %b required 0", busy);
        end
        for (int k = 0; k < 8; k++) begin
            step(noisy && k == 3, 1, noisy && k == 5, noisy && k == 6);
            n_checks++;
            if (load_ready !== 1'b1 || fifo_en !== 4'b1111 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL load_row%0d: ready=%b fifo_en=%b busy=%b required 1/1111/1",
                         k, load_ready, fifo_en, busy);
            end
        end
        step(noisy, 1, 0, noisy);
        n_checks++;
        if (load_ready !== 1'b0 || fifo_en !== 4'b0 || busy !== 1'b1 || col_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL load_full: ready=%b fifo_en=%b busy=%b col_valid=%b required 0/0000/1/1111",
                     load_ready, fifo_en, busy, col_valid);
        end
    endtask

    task automatic test_load_gaps();
        logic [11:0] pat = 12'b110101101101;
        int acc = 0;
        step(1, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, pat[k], 0, 0);
            n_checks++;
            if (load_ready !== 1'b1 || fifo_en !== {4{pat[k]}}) begin
                n_fail++;
                $display("FAIL gap_cycle%0d: ready=%b fifo_en=%b required 1/%b",
                         k, load_ready, fifo_en, {4{pat[k]}});
            end
            acc += int'(pat[k]);
        end
        step(0, 1, 0, 0);
        n_checks++;
        if (acc != 8 || load_ready !== 1'b0 || fifo_en !== 4'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_full: accepts=%0d ready=%b fifo_en=%b busy=%b required 8/0/0000/1",
                     acc, load_ready, fifo_en, busy);
        end
    endtask

    task automatic test_drain(input bit noisy);
        logic [3:0] prev = 4'b0;
        step(noisy, 0, 1, 0);
        n_checks++;
        if (fifo_en !== 4'b0 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_go_cycle: fifo_en=%b ready=%b required 0000/0", fifo_en, load_ready);
        end
        for (int k = 0; k < 11; k++) begin
            step(noisy && (k == 2 || k == 7), noisy && k == 3, noisy && k == 4, 0);
            n_checks++;
            if (fifo_en !== drain_pat[k] || col_valid !== prev || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_cycle%0d: fifo_en=%b col_valid=%b busy=%b done=%b required %b/%b/1/0",
                         k, fifo_en, col_valid, busy, done, drain_pat[k], prev);
            end
            prev = drain_pat[k];
        end
        step(noisy, 0, 0, 0);
        n_checks++;
        if (done !== 1'b1 || fifo_en !== 4'b0 || col_valid !== 4'b1000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_done: done=%b fifo_en=%b col_valid=%b busy=%b required 1/0000/1000/1",
                     done, fifo_en, col_valid, busy);
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || col_valid !== 4'b0 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle: done=%b busy=%b col_valid=%b ready=%b required 0/0/0000/0",
                     done, busy, col_valid, load_ready);
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp;
        logic [3:0] prev = 4'b0;
        int en_cnt [4] = '{0, 0, 0, 0};
        test_load_full(0);
        step(0, 0, 1, 0);
        for (int k = 0; k < 14; k++) begin
            logic sl;
            sl  = (k >= 5 && k <= 7);
            exp = sl ? 4'b0 : drain_pat[(k > 7) ? k - 3 : k];
            step(0, 0, 0, sl);
            n_checks++;
            if (fifo_en !== exp || col_valid !== prev || done !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: fifo_en=%b col_valid=%b done=%b required %b/%b/0",
                         k, fifo_en, col_valid, done, exp, prev);
            end
            for (int c = 0; c < 4; c++) en_cnt[c] += int'(fifo_en[c]);
            prev = exp;
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: done=%b required 1", done);
        end
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (en_cnt[c] != 8) begin
                n_fail++;
                $display("FAIL stall_col%0d_enables: got %0d required 8", c, en_cnt[c]);
            end
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_drain();
        test_load_full(0);
        step(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        n_checks++;
        if (fifo_en !== 4'b1111) begin
            n_fail++;
            $display("FAIL pre_reset_drain4: fifo_en=%b required 1111", fifo_en);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (fifo_en !== 4'b0 || load_ready !== 1'b0 || busy !== 1'b0 || col_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL async_reset: fifo_en=%b ready=%b busy=%b col_valid=%b required 0000/0/0/0000",
                     fifo_en, load_ready, busy, col_valid);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        reset = 1'b1;
        test_load_full(0);
        test_drain(0);
    endtask

    initial begin
        test_reset();
        test_load_full(0);
        test_drain(0);
        test_load_gaps();
        test_drain(0);
        test_stall();
        test_reset_mid_drain();
        test_load_full(1);
        test_drain(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
